// File: rtl/sqrt_arb_pkg.sv
// Shared definitions for the shared square-root scheduler: arbiter states,
// default sizes, root-width derivation and the round-robin pointer advance.
package sqrt_arb_pkg;

   localparam int NREQ_DEF = 2;
   localparam int IN_W_DEF = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // The root of an IN_W-bit radicand needs half as many bits.
   function automatic int calc_out_w(input int in_w);
      return in_w / 2;
   endfunction

   // Pointer for the next arbitration round: one past the last owner, wrapping.
   function automatic int rr_next(input int owner, input int nreq);
      return (owner >= nreq - 1) ? 0 : owner + 1;
   endfunction

endpackage

// File: rtl/sqrt_iter.sv
// Restoring digit-recurrence integer square root, one root bit per cycle.
// A start pulse loads the radicand; OUT_W steps follow. The done pulse is
// asserted during the final step, and root/rem carry that step's results
// (the values the internal registers take at the same edge), so the owner
// can capture the final answer without an extra cycle.
module sqrt_iter
   import sqrt_arb_pkg::*;
#(
   parameter  int IN_W  = IN_W_DEF,
   localparam int OUT_W = calc_out_w(IN_W),
   localparam int REM_W = OUT_W + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IN_W-1:0]  radicand,
   output logic             done,
   output logic [OUT_W-1:0] root,
   output logic [REM_W-1:0] rem
);

   localparam int CNT_W = $clog2(OUT_W + 1);

   logic [IN_W-1:0]  rad_q;
   logic [OUT_W-1:0] root_q;
   logic [REM_W-1:0] rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;

   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] trial;
   logic [REM_W:0]   diff;
   logic [OUT_W-1:0] root_nx;
   logic [REM_W-1:0] rem_nx;

   // One digit step: bring down two radicand bits, try (root<<2)|1.
   always_comb begin
      rem_sh = REM_W'({rem_q, rad_q[IN_W-1 -: 2]});
      trial  = {root_q, 2'b01};
      diff   = {1'b0, rem_sh} - {1'b0, trial};
      if (diff[REM_W]) begin
         rem_nx  = rem_sh;
         root_nx = OUT_W'({root_q, 1'b0});
      end else begin
         rem_nx  = diff[REM_W-1:0];
         root_nx = OUT_W'({root_q, 1'b1});
      end
   end

   assign done = run_q && (cnt_q == '0);
   assign root = root_nx;
   assign rem  = rem_nx;

   // Operand capture on start, then one step per cycle until the counter expires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rad_q  <= '0;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
      end else if (start) begin
         rad_q  <= radicand;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= CNT_W'(OUT_W - 1);
         run_q  <= 1'b1;
      end else if (run_q) begin
         rad_q  <= rad_q << 2;
         root_q <= root_nx;
         rem_q  <= rem_nx;
         cnt_q  <= cnt_q - CNT_W'(1);
         if (cnt_q == '0) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sqrt_share_arb.sv
// Round-robin scheduler sharing one iterative square-root engine among NREQ
// requesters. Handshakes: a transfer happens on a rising edge where valid and
// ready are both high; valid may not depend on ready, and a response stays
// valid with a stable root until its owner accepts it.
// Optional build macro SQRT_ROUND_EN: round the root to nearest (saturating)
// instead of returning floor(sqrt).
module sqrt_share_arb
   import sqrt_arb_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   parameter  int IN_W  = IN_W_DEF,
   localparam int OUT_W = calc_out_w(IN_W)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*IN_W-1:0] req_data,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [OUT_W-1:0]     rsp_root,
   output logic                 busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int REM_W = OUT_W + 2;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [OUT_W-1:0] root_q, root_d;

   logic [NREQ-1:0]  rv;
   logic [PTR_W-1:0] off;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] grant;
   logic             grant_vld;
   logic [IN_W-1:0]  radicand;
   logic             own_rdy;

   logic             start;
   logic             eng_done;
   logic [OUT_W-1:0] eng_root;
   logic [REM_W-1:0] eng_rem;
   logic [OUT_W-1:0] root_fin;

   // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
   always_comb begin
      rv        = NREQ'({req_valid, req_valid} >> rr_ptr_q);
      off       = '0;
      grant_vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rv[k]) begin
            off       = PTR_W'(k);
            grant_vld = 1'b1;
         end
      end
      sum = {1'b0, rr_ptr_q} + {1'b0, off};
      if (sum >= (PTR_W + 1)'(NREQ)) begin
         sum = sum - (PTR_W + 1)'(NREQ);
      end
      grant = sum[PTR_W-1:0];
   end

   // Select the granted requester's radicand.
   always_comb begin
      radicand = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant == PTR_W'(k)) begin
            radicand = req_data[k*IN_W +: IN_W];
         end
      end
   end

   // Per-requester handshake vectors; non-owner rsp_ready bits are masked off.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_ready[k] = (state_q == IDLE) && grant_vld && (grant == PTR_W'(k));
         rsp_valid[k] = (state_q == DONE) && (owner_q == PTR_W'(k));
      end
      own_rdy = |(rsp_valid & rsp_ready);
   end

`ifdef SQRT_ROUND_EN
   // Round to nearest: bump the root when the final remainder exceeds it.
   always_comb begin
      if ((eng_rem > REM_W'(eng_root)) && (eng_root != '1)) begin
         root_fin = eng_root + OUT_W'(1);
      end else begin
         root_fin = eng_root;
      end
   end
`else
   // Floor result; the remainder is only needed for rounding.
   logic unused_rem;
   assign root_fin   = eng_root;
   assign unused_rem = ^eng_rem;
`endif

   // Arbiter next-state: accept in IDLE, wait for the engine, hold the result.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      root_d   = root_q;
      start    = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               start   = 1'b1;
               owner_d = grant;
               state_d = CALC;
            end
         end
         CALC: begin
            if (eng_done) begin
               root_d  = root_fin;
               state_d = DONE;
            end
         end
         DONE: begin
            if (own_rdy) begin
               rr_ptr_d = PTR_W'(rr_next(int'(owner_q), NREQ));
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter registers; reset aborts any operation without a response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         root_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         root_q   <= root_d;
      end
   end

   assign rsp_root = root_q;
   assign busy     = (state_q != IDLE);

   sqrt_iter #(
      .IN_W (IN_W)
   ) u_iter (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .radicand (radicand),
      .done     (eng_done),
      .root     (eng_root),
      .rem      (eng_rem)
   );

endmodule

// File: tb/tb_sqrt_share_arb.sv
// Self-checking bench for sqrt_share_arb: scoreboard of expected roots and
// owners, pushed at each accepting edge and popped when a response appears.
module tb_sqrt_share_arb;

   localparam int NREQ  = 2;
   localparam int IN_W  = 28;
   localparam int OUT_W = IN_W / 2;
   localparam int TMO   = 100;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*IN_W-1:0] req_data;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [OUT_W-1:0]     rsp_root;
   logic                 busy;

   logic [OUT_W-1:0] exp_q[$];
   int               own_q[$];
   int               n_checks;
   int               n_fail;
   int               cyc;

   sqrt_share_arb #(
      .NREQ (NREQ),
      .IN_W (IN_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_root  (rsp_root),
      .busy      (busy)
   );

   // Clock, cycle counter and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Reference square root by bitwise search on 64-bit integers.
   function automatic logic [OUT_W-1:0] model_root(input logic [IN_W-1:0] x);
      longint r, t, xl;
      r  = 0;
      xl = longint'(x);
      for (int b = OUT_W - 1; b >= 0; b--) begin
         t = r + (longint'(1) << b);
         if (t * t <= xl) r = t;
      end
`ifdef SQRT_ROUND_EN
      if (((xl - r * r) > r) && (r < ((longint'(1) << OUT_W) - 1))) r = r + 1;
`endif
      return OUT_W'(r);
   endfunction

   // Driver: present a request on requester r, wait for accept, record expectation.
   task automatic send(input int r, input logic [IN_W-1:0] d, output int waited, output int acc_cyc);
      @(negedge clk);
      req_valid[r] = 1'b1;
      req_data[r*IN_W +: IN_W] = d;
      waited = 0;
      #1;
      while (!req_ready[r] && waited < TMO) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!req_ready[r]) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: req%0d req_ready=%b, required bit %0d high", r, req_ready, r);
         req_valid[r] = 1'b0;
         acc_cyc = -1;
      end else begin
         @(posedge clk);
         exp_q.push_back(model_root(d));
         own_q.push_back(r);
         @(negedge clk);
         acc_cyc = cyc;
         req_valid[r] = 1'b0;
      end
   endtask

   // Driver: count edges from accept until a response shows, watching busy.
   task automatic wait_rsp(output logic [NREQ-1:0] vld, output logic [OUT_W-1:0] root,
                           output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      #1;
      while (rsp_valid == '0 && lat < TMO) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         #1;
         lat++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (rsp_valid == '0) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required a response", rsp_valid, lat);
      end
      vld  = rsp_valid;
      root = rsp_root;
   endtask

   // Driver: accept the pending response on requester r.
   task automatic respond(input int r);
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready[r] = 1'b0;
   endtask

   // Scoreboard pop: expected root and one-hot owner vector.
   task automatic pop_exp(output logic [OUT_W-1:0] er, output logic [NREQ-1:0] ev);
      int eo;
      er = 'x;
      ev = 'x;
      if (exp_q.size() > 0) begin
         er = exp_q.pop_front();
         eo = own_q.pop_front();
         ev = '0;
         ev[eo] = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = '0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
      n_checks++; if (rsp_root !== '0) begin n_fail++; $display("FAIL reset_rsp_root: got %0d, required 0", rsp_root); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single();
      int waited, acc, lat;
      bit busy_ok;
      logic [NREQ-1:0] vld, ev;
      logic [OUT_W-1:0] root, er;
      send(0, 28'd144, waited, acc);
      n_checks++; if (waited !== 0) begin n_fail++; $display("FAIL single_ready_wait: waited %0d cycles, required 0", waited); end
      wait_rsp(vld, root, lat, busy_ok);
      pop_exp(er, ev);
      n_checks++; if (lat !== OUT_W) begin n_fail++; $display("FAIL single_latency: got %0d, required %0d", lat, OUT_W); end
      n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL single_busy: busy dropped, required high throughout"); end
      n_checks++; if (vld !== ev) begin n_fail++; $display("FAIL single_rsp_valid: got %b, required %b", vld, ev); end
      n_checks++; if (root !== er) begin n_fail++; $display("FAIL single_root: got %0d, required %0d", root, er); end
      n_checks++; if (root !== 14'd12) begin n_fail++; $display("FAIL single_root_const: got %0d, required 12", root); end
      respond(0);
      #1;
      n_checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: rsp_valid=%b busy=%b, required 0/0", rsp_valid, busy); end
   endtask

   task automatic test_radicands();
      logic [IN_W-1:0]  din[4];
      logic [OUT_W-1:0] tab[4];
      int waited, acc, lat;
      bit busy_ok;
      logic [NREQ-1:0] vld, ev;
      logic [OUT_W-1:0] root, er;
      logic [IN_W-1:0] rnd;
      din[0] = 28'd0; din[1] = 28'd10; din[2] = 28'd15; din[3] = 28'd268435455;
`ifdef SQRT_ROUND_EN
      tab[0] = 14'd0; tab[1] = 14'd3; tab[2] = 14'd4; tab[3] = 14'd16383;
`else
      tab[0] = 14'd0; tab[1] = 14'd3; tab[2] = 14'd3; tab[3] = 14'd16383;
`endif
      for (int i = 0; i < 4; i++) begin
         send(1, din[i], waited, acc);
         wait_rsp(vld, root, lat, busy_ok);
         pop_exp(er, ev);
         n_checks++; if (vld !== ev) begin n_fail++; $display("FAIL radicand_valid[%0d]: got %b, required %b", i, vld, ev); end
         n_checks++; if (root !== er) begin n_fail++; $display("FAIL radicand_root[%0d]: got %0d, required %0d", i, root, er); end
         n_checks++; if (root !== tab[i]) begin n_fail++; $display("FAIL radicand_table[%0d]: got %0d, required %0d", i, root, tab[i]); end
         respond(1);
      end
      for (int i = 0; i < 4; i++) begin
         rnd = IN_W'($urandom_range(0, 32'h0FFF_FFFF));
         send(0, rnd, waited, acc);
         wait_rsp(vld, root, lat, busy_ok);
         pop_exp(er, ev);
         n_checks++; if (root !== er || vld !== ev) begin n_fail++; $display("FAIL random_root[%0d]: x=%0d got %0d/%b, required %0d/%b", i, rnd, root, vld, er, ev); end
         n_checks++; if (lat !== OUT_W) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d, required %0d", i, lat, OUT_W); end
         respond(0);
      end
   endtask

   task automatic test_round_robin();
      int exp_owner, waited, lat, eo;
      bit busy_ok;
      logic [NREQ-1:0] vld, ev, exp_vec, rdy;
      logic [OUT_W-1:0] root, er;
      @(negedge clk);
      reset = 1'b1;
      req_data[0 +: IN_W]    = 28'd49;
      req_data[IN_W +: IN_W] = 28'd81;
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_owner = 0;
      for (int op = 0; op < 4; op++) begin
         #1;
         waited = 0;
         while (req_ready == '0 && waited < TMO) begin
            @(negedge clk);
            #1;
            waited++;
         end
         exp_vec = '0;
         exp_vec[exp_owner] = 1'b1;
         n_checks++; if (req_ready !== exp_vec) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b, required %b", op, req_ready, exp_vec); end
         rdy = req_ready;
         eo  = rdy[1] ? 1 : 0;
         @(posedge clk);
         exp_q.push_back(model_root(req_data[eo*IN_W +: IN_W]));
         own_q.push_back(eo);
         @(negedge clk);
         wait_rsp(vld, root, lat, busy_ok);
         pop_exp(er, ev);
         n_checks++; if (vld !== ev) begin n_fail++; $display("FAIL rr_rsp_valid[%0d]: got %b, required %b", op, vld, ev); end
         n_checks++; if (root !== er) begin n_fail++; $display("FAIL rr_root[%0d]: got %0d, required %0d", op, root, er); end
         respond(eo);
         exp_owner = (exp_owner + 1) % NREQ;
      end
      req_valid = '0;
   endtask

   task automatic test_hold();
      int waited, acc, lat;
      bit busy_ok;
      logic [NREQ-1:0] vld, ev;
      logic [OUT_W-1:0] root, er;
      send(1, 28'd100, waited, acc);
      wait_rsp(vld, root, lat, busy_ok);
      pop_exp(er, ev);
      n_checks++; if (vld !== ev || root !== er) begin n_fail++; $display("FAIL hold_first: got %0d/%b, required %0d/%b", root, vld, er, ev); end
      rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1;
      req_data[0 +: IN_W] = 28'd200;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (rsp_valid !== ev) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b, required %b", i, rsp_valid, ev); end
         n_checks++; if (rsp_root !== er) begin n_fail++; $display("FAIL hold_root[%0d]: got %0d, required %0d", i, rsp_root, er); end
         n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL hold_req_ready[%0d]: got %b, required 0", i, req_ready); end
         @(negedge clk);
         #1;
      end
      rsp_ready[0] = 1'b0;
      respond(1);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL hold_next_grant: got %b, required 01", req_ready); end
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL hold_released: rsp_valid=%b, required 0", rsp_valid); end
      @(posedge clk);
      exp_q.push_back(model_root(28'd200));
      own_q.push_back(0);
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_rsp(vld, root, lat, busy_ok);
      pop_exp(er, ev);
      n_checks++; if (vld !== ev || root !== er) begin n_fail++; $display("FAIL hold_second: got %0d/%b, required %0d/%b", root, vld, er, ev); end
      n_checks++; if (lat !== OUT_W) begin n_fail++; $display("FAIL hold_second_latency: got %0d, required %0d", lat, OUT_W); end
      respond(0);
   endtask

   task automatic test_abort();
      int waited, acc, lat;
      bit busy_ok, seen;
      logic [NREQ-1:0] vld, ev;
      logic [OUT_W-1:0] root, er;
      logic [OUT_W-1:0] dropped;
      int dropped_own;
      send(0, 28'd1000, waited, acc);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL abort_rsp_valid: got %b, required 0", rsp_valid); end
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL abort_req_ready: got %b, required 0", req_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
      n_checks++; if (rsp_root !== '0) begin n_fail++; $display("FAIL abort_rsp_root: got %0d, required 0", rsp_root); end
      reset = 1'b0;
      if (exp_q.size() > 0) begin
         dropped     = exp_q.pop_back();
         dropped_own = own_q.pop_back();
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid !== '0) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_silent: response seen=%b busy=%b, required 0/0", seen, busy); end
      send(0, 28'd256, waited, acc);
      wait_rsp(vld, root, lat, busy_ok);
      pop_exp(er, ev);
      n_checks++; if (vld !== ev || root !== er) begin n_fail++; $display("FAIL abort_fresh: got %0d/%b, required %0d/%b", root, vld, er, ev); end
      n_checks++; if (root !== 14'd16) begin n_fail++; $display("FAIL abort_fresh_const: got %0d, required 16", root); end
      respond(0);
   endtask

   task automatic test_back_to_back();
      logic [IN_W-1:0]  din[3];
      logic [OUT_W-1:0] tab[3];
      int waited, acc, prev_acc, lat;
      bit busy_ok;
      logic [NREQ-1:0] vld, ev;
      logic [OUT_W-1:0] root, er;
      din[0] = 28'd1; din[1] = 28'd4; din[2] = 28'd9;
      tab[0] = 14'd1; tab[1] = 14'd2; tab[2] = 14'd3;
      prev_acc = 0;
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(0, din[i], waited, acc);
         if (i > 0) begin
            n_checks++; if (acc - prev_acc !== OUT_W + 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d, required %0d", i, acc - prev_acc, OUT_W + 2); end
         end
         prev_acc = acc;
         wait_rsp(vld, root, lat, busy_ok);
         pop_exp(er, ev);
         n_checks++; if (vld !== ev || root !== er) begin n_fail++; $display("FAIL b2b_root[%0d]: got %0d/%b, required %0d/%b", i, root, vld, er, ev); end
         n_checks++; if (root !== tab[i]) begin n_fail++; $display("FAIL b2b_const[%0d]: got %0d, required %0d", i, root, tab[i]); end
      end
      @(negedge clk);
      rsp_ready[0] = 1'b0;
   endtask

   // Test sequence and final report.
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = '0;
      test_reset();
      test_single();
      test_radicands();
      test_round_robin();
      test_hold();
      test_abort();
      test_back_to_back();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_share_arb.md
Name: sqrt_share_arb

Overview:
Round-robin scheduler that shares one iterative integer square-root engine between NREQ requesters. Example requesters are the side-length phase and the triangle-area phase of the geofence datapath. The block accepts one radicand at a time through a valid/ready handshake and computes floor(sqrt) at one result bit per cycle. It returns the root to the owning requester through a held response handshake.

Parameters:
NREQ, 2, number of requesters (2..4)
IN_W, 28, radicand width; must be even
OUT_W, IN_W/2, root width; derived, not overridable

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_data  input  NREQ*IN_W  radicands; requester i occupies bits [i*IN_W +: IN_W], unsigned
rsp_valid  output  NREQ  one-hot result valid for the owning requester
rsp_ready  input  NREQ  per-requester result accept
rsp_root  output  OUT_W  root; valid only while any rsp_valid bit is high
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr 0, owner 0. Reset asserted mid-operation aborts silently and no response is issued.
- States: IDLE, CALC, DONE.
- IDLE: grant is computed combinationally as the first i with req_valid[i] set, scanning from rr_ptr upward and wrapping. req_ready = grant (one-hot); it is zero when no request is valid.
  - On a handshake, the block latches req_data[grant], owner = grant, clears root and remainder, sets iteration counter to OUT_W-1, and moves to CALC.
- CALC: one restoring digit step per cycle. Each step brings down 2 radicand bits and tries (root<<2)|1 against the partial remainder. The counter decrements each step; after the step at counter 0, the state moves to DONE.
- DONE: rsp_valid[owner]=1; rsp_root is registered and stable. It holds until rsp_ready[owner] is high.
  - On that handshake: state returns to IDLE and rr_ptr = owner+1, wrapping to 0 after NREQ-1.
  - rsp_ready bits of non-owners are ignored.
- Latency: rsp_valid rises OUT_W cycles after the accepting edge (14 at defaults).
- Throughput: minimum OUT_W+2 cycles per operation. req_ready stays low in CALC and DONE, so a request that arrives while a response is handshaking is accepted on the following IDLE cycle.
- Requester i must hold req_data stable only until its handshake; the operand is captured at accept.
- Arithmetic: remainder register OUT_W+2 bits, unsigned, no overflow for any IN_W input. Radicand 0 returns 0.
- Starvation bound: a continuously valid requester is granted within NREQ-1 other operations.

Optional Feature:
SQRT_ROUND_EN
- Defined: the result is rounded to nearest. If the final remainder > root, rsp_root = root+1, saturating at 2^OUT_W-1. The rounding adds no cycles; it is applied on the CALC to DONE transition.
- Undefined: floor(sqrt) only.

Decomposition:
- Package sqrt_arb_pkg: state enum (IDLE/CALC/DONE), default NREQ/IN_W constants, OUT_W derivation function, rr next-pointer function.
- Sub-module sqrt_iter: the digit-recurrence engine.
  - Inputs: start, radicand.
  - Outputs: done pulse, root, rem.
  - Arbiter FSM and response registers stay in sqrt_share_arb.

Test Plan:
1. req0 only, data 144 -> req_ready[0] same cycle; rsp_valid=01 exactly 14 cycles after accept; root 12; busy high throughout.
2. Radicands 0, 10, 15, 268435455 on req1 -> roots 0, 3, 3, 16383. With SQRT_ROUND_EN -> 0, 3, 4, 16383 (saturated, since rem 32766 > root).
3. Both valid from reset with data 49/81 -> req0 served first (root 7), then req1 (root 9). Both held valid again -> req0 next, showing alternation over 4 operations.
4. rsp_ready[owner] low for 5 cycles -> rsp_valid and rsp_root stay stable, req_ready stays 0. rsp_ready of the non-owner high during this window is ignored.
5. Reset asserted at CALC step 6 -> all outputs 0 next cycle, no rsp_valid. A fresh request 256 afterwards -> root 16.
6. Back-to-back req0 stream 1,4,9 -> roots 1,2,3 at a spacing of 16 cycles between accepts.
